// File: rtl/bsg_link_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bsg_link_sched_pkg
// Purpose  : Shared state encoding and credit sizing helpers for the DDR link
//            credit scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package bsg_link_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } sched_state_e;

    // One extra bit so a full FIFO's worth of credit is representable.
    function automatic int credit_width(input int lg_fifo_depth);
        return lg_fifo_depth + 1;
    endfunction

    function automatic int credits_per_token(input int lg_credit_decimation);
        return 1 << lg_credit_decimation;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_link_sched_credit_ctr.sv
`default_nettype none
// ============================================================================
// Module   : bsg_link_sched_credit_ctr
// Purpose  : Per-channel token edge detector and credit counter.
//            Optional overflow clamp/flag: BSG_LINK_SCHED_CREDIT_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_link_sched_credit_ctr
    import bsg_link_sched_pkg::*;
#(
    parameter int  LG_FIFO_DEPTH        = 6,
    parameter int  LG_CREDIT_DECIMATION = 2,
    localparam int CW                   = credit_width(LG_FIFO_DEPTH)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          token_i,
    input  logic          grant_i,
    output logic [CW-1:0] credit_o,
    output logic          full_o,
    output logic          error_o
);

    localparam logic [CW-1:0] c_full = CW'(1) << LG_FIFO_DEPTH;
    localparam logic [CW-1:0] c_inc  = CW'(credits_per_token(LG_CREDIT_DECIMATION));

    logic          r_token;
    logic          r_edge;
    logic [CW-1:0] r_credit;
    logic [CW-1:0] w_credit_next;

    // The edge is registered so a return lands in the counter two cycles out.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_token <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_token <= token_i;
            r_edge  <= token_i ^ r_token;
        end
    end

`ifdef BSG_LINK_SCHED_CREDIT_CHECK_EN
    logic [CW:0] w_sum;
    logic        w_over;
    logic        r_error;

    always_comb begin
        w_sum         = {1'b0, r_credit} - {{CW{1'b0}}, grant_i}
                        + (r_edge ? {1'b0, c_inc} : {(CW+1){1'b0}});
        w_over        = (w_sum > {1'b0, c_full});
        w_credit_next = w_over ? c_full : w_sum[CW-1:0];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_error <= 1'b0;
        end else if (w_over) begin
            r_error <= 1'b1;
        end
    end

    assign error_o = r_error;
`else
    always_comb begin
        w_credit_next = r_credit - CW'(grant_i) + (r_edge ? c_inc : {CW{1'b0}});
    end

    assign error_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_credit <= c_full;
        end else begin
            r_credit <= w_credit_next;
        end
    end

    assign credit_o = r_credit;
    assign full_o   = (r_credit == c_full);

endmodule
`default_nettype wire

// File: rtl/bsg_link_ddr_credit_sched.sv
`default_nettype none
// ============================================================================
// Module   : bsg_link_ddr_credit_sched
// Purpose  : Round-robin, credit-gated transmit scheduler for the DDR link.
//            Optional overflow clamp/flag: BSG_LINK_SCHED_CREDIT_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_link_ddr_credit_sched
    import bsg_link_sched_pkg::*;
#(
    parameter int  NUM_CH               = 2,
    parameter int  WIDTH                = 16,
    parameter int  LG_FIFO_DEPTH        = 6,
    parameter int  LG_CREDIT_DECIMATION = 2,
    parameter int  INIT_CYCLES          = 8,
    localparam int CH_W                 = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CW                   = credit_width(LG_FIFO_DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic [NUM_CH-1:0]      req_v_i,
    input  logic [NUM_CH*WIDTH-1:0] req_data_i,
    output logic [NUM_CH-1:0]      grant_o,
    output logic                   link_v_o,
    output logic [WIDTH-1:0]       link_data_o,
    output logic [CH_W-1:0]        link_ch_o,
    input  logic                   link_ready_i,
    input  logic [NUM_CH-1:0]      token_i,
    output logic [NUM_CH*CW-1:0]   credit_o,
    output logic                   drained_o,
    output logic                   error_o
);

    localparam int              CNT_W       = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_init_last = CNT_W'(INIT_CYCLES - 1);

    sched_state_e      r_state;
    sched_state_e      w_state_next;
    logic [CNT_W-1:0]  r_init_cnt;
    logic [CH_W-1:0]   r_last_grant;
    logic [CH_W-1:0]   w_sel;
    logic [WIDTH-1:0]  w_sel_data;
    logic              w_found;
    logic              w_free;
    logic              w_fire;
    logic              w_run;
    logic              w_all_full;
    logic [NUM_CH-1:0] w_elig;
    logic [NUM_CH-1:0] w_has_credit;
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_err;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        bsg_link_sched_credit_ctr #(
            .LG_FIFO_DEPTH        (LG_FIFO_DEPTH),
            .LG_CREDIT_DECIMATION (LG_CREDIT_DECIMATION)
        ) u_ctr (
            .clk_i    (clk_i),
            .reset_i  (reset_i),
            .token_i  (token_i[c]),
            .grant_i  (grant_o[c]),
            .credit_o (credit_o[c*CW +: CW]),
            .full_o   (w_full[c]),
            .error_o  (w_err[c])
        );
        assign w_has_credit[c] = |credit_o[c*CW +: CW];
    end

    assign w_all_full = &w_full;
    assign error_o    = |w_err;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= ST_IDLE;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_init_cnt <= (r_state == ST_INIT) ? r_init_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (enable_i) w_state_next = ST_INIT;
            ST_INIT:  if (r_init_cnt == c_init_last) w_state_next = ST_RUN;
            ST_RUN:   if (!enable_i) w_state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (!link_v_o && w_all_full) begin
                    w_state_next = ST_IDLE;
                end else if (enable_i) begin
                    w_state_next = ST_RUN;
                end
            end
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_run     = (r_state == ST_RUN);
        drained_o = (r_state == ST_IDLE) && w_all_full;
    end

    // Round robin: first pass covers channels above last_grant, second wraps.
    always_comb begin
        w_free     = !link_v_o || link_ready_i;
        w_elig     = w_run ? (req_v_i & w_has_credit) : '0;
        w_found    = 1'b0;
        w_sel      = '0;
        w_sel_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!w_found && w_elig[c] && (CH_W'(c) > r_last_grant)) begin
                w_found = 1'b1;
                w_sel   = CH_W'(c);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (!w_found && w_elig[c]) begin
                w_found = 1'b1;
                w_sel   = CH_W'(c);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_sel == CH_W'(c)) begin
                w_sel_data = req_data_i[c*WIDTH +: WIDTH];
            end
        end
        w_fire  = w_found && w_free;
        grant_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            grant_o[c] = w_fire && (w_sel == CH_W'(c));
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            link_v_o     <= 1'b0;
            link_data_o  <= '0;
            link_ch_o    <= '0;
            r_last_grant <= CH_W'(NUM_CH - 1);
        end else if (w_fire) begin
            link_v_o     <= 1'b1;
            link_data_o  <= w_sel_data;
            link_ch_o    <= w_sel;
            r_last_grant <= w_sel;
        end else if (link_ready_i) begin
            link_v_o     <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bsg_link_ddr_credit_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_link_ddr_credit_sched
// Purpose  : Directed vector bench for the DDR link credit scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_link_ddr_credit_sched;

    localparam int CW = 7;

    typedef struct {
        logic [1:0]  req;
        logic        rdy;
        logic [1:0]  grant;
        logic        v;
        logic        ch;
        logic [15:0] data;
    } vec_t;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        enable     = 1'b0;
    logic        link_ready = 1'b0;
    logic [1:0]  req_v      = 2'b00;
    logic [1:0]  token      = 2'b00;
    logic [15:0] d0         = 16'hA0A0;
    logic [15:0] d1         = 16'hB1B1;
    logic [31:0] req_data;
    logic [1:0]  grant;
    logic        link_v;
    logic [15:0] link_data;
    logic        link_ch;
    logic [13:0] credit;
    logic [6:0]  cr0;
    logic [6:0]  cr1;
    logic        drained;
    logic        error;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_g;
    vec_t vecs [14];

    assign req_data = {d1, d0};
    assign cr0      = credit[CW-1:0];
    assign cr1      = credit[2*CW-1:CW];

    always #5 clk = ~clk;

    bsg_link_ddr_credit_sched dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .enable_i     (enable),
        .req_v_i      (req_v),
        .req_data_i   (req_data),
        .grant_o      (grant),
        .link_v_o     (link_v),
        .link_data_o  (link_data),
        .link_ch_o    (link_ch),
        .link_ready_i (link_ready),
        .token_i      (token),
        .credit_o     (credit),
        .drained_o    (drained),
        .error_o      (error)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic go_run();
        enable = 1'b1;
        req_v  = 2'b11;
        link_ready = 1'b1;
        cyc();
        for (int k = 0; k < 8; k++) begin
            #3;
            check($sformatf("init_nogrant%0d", k), 32'(grant), 32'd0);
            cyc();
        end
    endtask

    initial begin
        vecs[0]  = '{2'b11, 1'b1, 2'b01, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{2'b11, 1'b1, 2'b10, 1'b1, 1'b0, 16'hA0A0};
        vecs[2]  = '{2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 16'hB1B1};
        vecs[3]  = '{2'b11, 1'b1, 2'b10, 1'b1, 1'b0, 16'hA0A0};
        vecs[4]  = '{2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 16'hB1B1};
        vecs[5]  = '{2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 16'hA0A0};
        vecs[6]  = '{2'b10, 1'b1, 2'b10, 1'b1, 1'b0, 16'hA0A0};
        vecs[7]  = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 16'hB1B1};
        vecs[8]  = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 16'h0000};
        vecs[9]  = '{2'b11, 1'b0, 2'b01, 1'b0, 1'b1, 16'h0000};
        vecs[10] = '{2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 16'hA0A0};
        vecs[11] = '{2'b11, 1'b1, 2'b10, 1'b1, 1'b0, 16'hA0A0};
        vecs[12] = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 16'hB1B1};
        vecs[13] = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 16'h0000};

        // Reset values
        req_v = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant",   32'(grant),     32'd0);
        check("rst_link_v",  32'(link_v),    32'd0);
        check("rst_data",    32'(link_data), 32'd0);
        check("rst_ch",      32'(link_ch),   32'd0);
        check("rst_cr0",     32'(cr0),       32'd64);
        check("rst_cr1",     32'(cr1),       32'd64);
        check("rst_drained", 32'(drained),   32'd1);
        check("rst_error",   32'(error),     32'd0);
        rst = 1'b0;
        cyc();
        #3;
        check("idle_nogrant", 32'(grant), 32'd0);
        cyc();

        // INIT then round robin table
        go_run();
        check("run_cr0", 32'(cr0), 32'd64);
        check("run_cr1", 32'(cr1), 32'd64);
        for (int i = 0; i < 14; i++) begin
            req_v      = vecs[i].req;
            link_ready = vecs[i].rdy;
            #3;
            check($sformatf("tbl%0d_grant", i), 32'(grant),  32'(vecs[i].grant));
            check($sformatf("tbl%0d_v", i),     32'(link_v), 32'(vecs[i].v));
            check($sformatf("tbl%0d_ch", i),    32'(link_ch), 32'(vecs[i].ch));
            if (vecs[i].v) check($sformatf("tbl%0d_data", i), 32'(link_data), 32'(vecs[i].data));
            cyc();
        end
        #3;
        check("tbl_cr0", 32'(cr0), 32'd59);
        check("tbl_cr1", 32'(cr1), 32'd60);
        cyc();

        // Back-pressure hold
        req_v = 2'b01;
        link_ready = 1'b0;
        #3;
        check("hold_first_grant", 32'(grant), 32'd1);
        cyc();
        d0 = 16'h1234;
        for (int k = 0; k < 5; k++) begin
            #3;
            check($sformatf("hold%0d_grant", k), 32'(grant),     32'd0);
            check($sformatf("hold%0d_v", k),     32'(link_v),    32'd1);
            check($sformatf("hold%0d_data", k),  32'(link_data), 32'hA0A0);
            cyc();
        end
        link_ready = 1'b1;
        #3;
        check("release_grant", 32'(grant),     32'd1);
        check("release_data",  32'(link_data), 32'hA0A0);
        cyc();
        req_v = 2'b00;
        #3;
        check("release_next_v",    32'(link_v),    32'd1);
        check("release_next_data", 32'(link_data), 32'h1234);
        cyc();
        #3;
        check("release_empty", 32'(link_v), 32'd0);
        cyc();

        // ch0 credit exhaustion and recovery
        req_v = 2'b01;
        n_g = 0;
        for (int k = 0; k < 70; k++) begin
            #3;
            if (grant[0]) n_g++;
            cyc();
        end
        check("exhaust_grants", 32'(n_g), 32'd57);
        token[0] = 1'b1;
        #3;
        check("exhaust_cr0",     32'(cr0),   32'd0);
        check("exhaust_nogrant", 32'(grant), 32'd0);
        cyc();
        #3;
        check("token_lat1_cr0", 32'(cr0), 32'd0);
        cyc();
        #3;
        check("token_lat2_cr0", 32'(cr0), 32'd4);
        n_g = grant[0] ? 1 : 0;
        cyc();
        for (int k = 0; k < 19; k++) begin
            #3;
            if (grant[0]) n_g++;
            cyc();
        end
        check("refill_grants", 32'(n_g), 32'd4);
        #3;
        check("refill_cr0", 32'(cr0), 32'd0);

        // ch1 down to 10, then simultaneous grant and token edge
        req_v = 2'b10;
        n_g = 0;
        for (int k = 0; k < 50; k++) begin
            #3;
            if (grant[1]) n_g++;
            cyc();
        end
        check("ch1_grants", 32'(n_g), 32'd50);
        req_v = 2'b00;
        token[1] = 1'b1;
        #3;
        check("ch1_cr10", 32'(cr1), 32'd10);
        cyc();
        req_v = 2'b10;
        #3;
        check("ch1_sim_grant", 32'(grant), 32'd2);
        cyc();
        req_v = 2'b00;
        #3;
        check("ch1_cr13", 32'(cr1), 32'd13);
        cyc();

        // Reset while a flit is held
        req_v = 2'b10;
        link_ready = 1'b0;
        #3;
        check("pre_rst_grant", 32'(grant), 32'd2);
        cyc();
        #3;
        check("pre_rst_v", 32'(link_v), 32'd1);
        rst   = 1'b1;
        token = 2'b00;
        #1;
        check("mid_rst_v",     32'(link_v), 32'd0);
        check("mid_rst_grant", 32'(grant),  32'd0);
        check("mid_rst_cr1",   32'(cr1),    32'd64);
        cyc();
        enable = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        #3;
        check("post_rst_drained", 32'(drained), 32'd1);
        cyc();

        // Drain sequence
        go_run();
        req_v = 2'b01;
        for (int k = 0; k < 3; k++) begin
            #3;
            check($sformatf("dr_grant%0d", k), 32'(grant), 32'd1);
            cyc();
        end
        enable = 1'b0; req_v = 2'b00; link_ready = 1'b0;
        cyc();
        req_v = 2'b01;
        #3;
        check("drain_nogrant", 32'(grant),   32'd0);
        check("drain_held_v",  32'(link_v),  32'd1);
        check("drain_busy",    32'(drained), 32'd0);
        check("drain_cr0",     32'(cr0),     32'd61);
        cyc();
        link_ready = 1'b1;
        #3;
        check("drain_nogrant2", 32'(grant), 32'd0);
        cyc();
        enable = 1'b1;
        #3;
        check("drain_en_nogrant", 32'(grant),  32'd0);
        check("drain_flit_done",  32'(link_v), 32'd0);
        cyc();
        #3;
        check("rerun_grant", 32'(grant), 32'd1);
        cyc();
        enable = 1'b0; req_v = 2'b00;
        cyc();
        token[0] = 1'b1;
        #3;
        check("drain2_busy", 32'(drained), 32'd0);
        cyc();
        #3;
        check("drain2_cr0_lat", 32'(cr0), 32'd60);
        cyc();
        #3;
        check("drain2_cr0_full", 32'(cr0),     32'd64);
        check("drain2_not_idle", 32'(drained), 32'd0);
        cyc();
        req_v = 2'b01;
        #3;
        check("drained_idle",   32'(drained), 32'd1);
        check("idle_nogrant2",  32'(grant),   32'd0);
        cyc();

        // Token return while already full
        token[0] = 1'b0;
        cyc();
        cyc();
        #3;
`ifdef BSG_LINK_SCHED_CREDIT_CHECK_EN
        check("ovf_cr0",   32'(cr0),   32'd64);
        check("ovf_error", 32'(error), 32'd1);
`else
        check("wrap_cr0",  32'(cr0),   32'd68);
        check("ovf_error", 32'(error), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bsg_link_ddr_credit_sched.md
# bsg_link_ddr_credit_sched

Credit-based transmit scheduler for the DDR link upstream side, running in the io clock domain. It arbitrates several core channels onto one shared link output stage in round-robin order. Each channel's flits are gated by a per-channel credit counter that mirrors free space in that channel's downstream asynchronous FIFO. Credits are replenished by the toggling token that the downstream block returns, one toggle per credit batch.

## Interface
Parameters:
- NUM_CH, 2: number of requesting channels.
- WIDTH, 16: flit width.
- LG_FIFO_DEPTH, 6: log2 of the downstream FIFO depth; credits reset to 2^LG_FIFO_DEPTH.
- LG_CREDIT_DECIMATION, 2: each token toggle returns 2^LG_CREDIT_DECIMATION credits.
- INIT_CYCLES, 8: cycles spent in INIT before grants are allowed.

Ports:
- clk_i  in  1  io clock; all state on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  level; 1 = run, 0 = drain and stop.
- req_v_i  in  NUM_CH  channel c has a flit.
- req_data_i  in  NUM_CH*WIDTH  flit of channel c at bits [c*WIDTH +: WIDTH].
- grant_o  out  NUM_CH  one-hot yumi; the flit is consumed this cycle.
- link_v_o  out  1  output stage holds a valid flit.
- link_data_o  out  WIDTH  output flit.
- link_ch_o  out  $clog2(NUM_CH) (min 1)  channel of link_data_o.
- link_ready_i  in  1  link accepts the flit this cycle.
- token_i  in  NUM_CH  per-channel token, already synchronized to clk_i; each edge is one return.
- credit_o  out  NUM_CH*(LG_FIFO_DEPTH+1)  current credit counts.
- drained_o  out  1  in IDLE with all credits full.
- error_o  out  1  sticky credit-overflow flag.

## Operation
- FSM states: IDLE, INIT, RUN, DRAIN.
  - IDLE -> INIT when enable_i = 1.
  - INIT counts INIT_CYCLES cycles, then enters RUN.
  - RUN -> DRAIN when enable_i = 0.
  - DRAIN -> IDLE once the output stage is empty and every credit equals 2^LG_FIFO_DEPTH.
  - DRAIN -> RUN if enable_i returns to 1 before draining completes.
- Token detection: token_r <= token_i, and edge = token_i ^ token_r.
- Credit update per channel, in LG_FIFO_DEPTH+1 bits: credit_next = credit - grant + (edge ? 2^LG_CREDIT_DECIMATION : 0).
  - Simultaneous grant and edge on the same channel apply both updates.
- Eligibility: channel c is eligible when state = RUN, req_v_i[c] = 1, and credit[c] != 0.
- Arbitration:
  - The search starts at last_grant+1, wraps modulo NUM_CH, and picks the first eligible channel.
  - last_grant updates only when a grant is issued.
- A grant is issued only when the output stage is free, meaning link_v_o = 0 or link_ready_i = 1 in the same cycle.
- The granted flit and its channel load into the output stage.
- The output stage holds link_data_o and link_ch_o stable while link_v_o && !link_ready_i.
- DRAIN and IDLE issue no grants, but a flit already in the output stage still completes.
- Token edges are counted in every state, including IDLE and INIT.

## Timing
- Reset values:
  - state = IDLE; credits = 2^LG_FIFO_DEPTH; last_grant = NUM_CH-1; token_r = token_i sampled as 0.
  - link_v_o = 0; link_data_o = 0; link_ch_o = 0; grant_o = 0; error_o = 0; drained_o = 1.
- grant_o is combinational from registered state, req_v_i and link_ready_i; it is never asserted in the same cycle that reset_i is high.
- Latency from grant to link_v_o is 1 cycle.
- Back-to-back grants are allowed every cycle while link_ready_i = 1.
- A token edge on token_i is visible in credit_o 2 cycles later: 1 cycle to register token_r, 1 cycle to update credit.
- A channel at credit 1 that is granted gets credit 0 and is ineligible from the next cycle.
- Reset asserted mid-operation discards the output stage flit; the downstream side is reset by the same link reset.

## Configuration
- BSG_LINK_SCHED_CREDIT_CHECK_EN defined:
  - If credit_next would exceed 2^LG_FIFO_DEPTH, the counter clamps to 2^LG_FIFO_DEPTH and error_o sets.
  - error_o stays set until reset.
- BSG_LINK_SCHED_CREDIT_CHECK_EN undefined:
  - No clamp; the arithmetic wraps modulo 2^(LG_FIFO_DEPTH+1).
  - error_o is tied to 0.

## Structure
- Shared package bsg_link_sched_pkg holds:
  - the state enum (IDLE, INIT, RUN, DRAIN);
  - the credit width function LG_FIFO_DEPTH+1;
  - the credit-per-token constant.
- Sub-module bsg_link_sched_credit_ctr is instantiated once per channel. It contains the token edge register, the credit counter and, under the macro, the overflow check.
- The round-robin arbiter, FSM and output stage live in the top module.

## Test plan
- Reset with NUM_CH=2, then enable_i=1 -> no grant for 8 cycles (INIT); first grant in cycle 9 of enable; credit_o = 64 per channel.
- Both req_v_i high and link_ready_i always 1 -> grants alternate ch0, ch1, ch0 ...; link_ch_o follows one cycle later.
- ch0 alone for 64 grants with no tokens -> credit 0, no further ch0 grants; one token_i[0] toggle -> credit 4 two cycles later; exactly 4 more grants.
- link_ready_i=0 for 5 cycles with a flit held -> link_data_o stable, no grants; ready=1 -> the held flit is accepted and a new grant is issued the same cycle.
- Grant and token edge on ch1 in the same cycle at credit 10 -> credit 13.
- enable_i=0 with 3 credits outstanding -> state DRAIN, no grants; after tokens return all credits to 64 -> IDLE, drained_o=1.
- With the macro defined, a token edge at credit 64 -> credit stays 64 and error_o=1.
